wr_stream_ctrl: RTL and testbench
=================================

WR_STREAM_CTRL -- requirements
Module: wr_stream_ctrl

Interface
REQ-001 Parameter DSIZE, default 8: data word width.
REQ-002 Parameter ADDRSIZE, default 4: FIFO address width; depth = 2^ADDRSIZE = 16.
REQ-003 Parameter AF_THRESH, default 14: almost-full threshold in words; legal range 1..2^ADDRSIZE.
REQ-004 wclk  input  1  write-domain clock; all logic rising-edge.
REQ-005 wrst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_data  input  DSIZE  upstream word.
REQ-008 s_ready  output  1  block can accept a word this cycle.
REQ-009 winc  output  1  write strobe to write-pointer/full logic and FIFO memory.
REQ-010 wdata  output  DSIZE  word written to FIFO memory when winc=1.
REQ-011 wfull  input  1  registered full flag from write-pointer/full logic.
REQ-012 wptr  input  ADDRSIZE+1  Gray-coded write pointer from write-pointer/full logic.
REQ-013 wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already synchronized into wclk.
REQ-014 wlevel  output  ADDRSIZE+1  write-side fill estimate, words.
REQ-015 walmost_full  output  1  wlevel >= AF_THRESH.

Function
REQ-016 Block SHALL contain a 2-entry skid buffer (head, tail) with FSM states EMPTY, ONE, TWO.
REQ-017 Upstream transfer SHALL occur on a cycle with s_valid=1 and s_ready=1; downstream transfer SHALL occur on a cycle with winc=1.
REQ-018 s_ready SHALL be registered: 1 in EMPTY and ONE, 0 in TWO.
REQ-019 winc SHALL equal (state != EMPTY) & ~wfull; wdata SHALL equal head entry.
REQ-020 Transitions: EMPTY->ONE on upstream transfer; ONE->TWO on upstream without downstream; ONE->EMPTY on downstream without upstream; ONE stays ONE on both (new word into head); TWO->ONE on downstream (tail moves to head); otherwise hold.
REQ-021 Words SHALL leave in arrival order; no word SHALL be dropped or duplicated.
REQ-022 While wfull=1, winc SHALL be 0 and buffer contents SHALL hold; at most 2 words are absorbed before s_ready drops.
REQ-023 Zero-bubble throughput: with wfull=0 and s_valid held 1, one word per cycle SHALL be written, first winc one cycle after first accepted word.
REQ-024 Gray-to-binary conversion SHALL be applied to wptr and wq2_rptr (bit i = XOR of Gray bits ADDRSIZE..i).
REQ-025 wlevel SHALL be registered, updated every cycle to bin(wptr) - bin(wq2_rptr) modulo 2^(ADDRSIZE+1); one-cycle latency from input change.
REQ-026 Pointer wrap (binary 31->0) SHALL give correct wlevel by the modular subtraction; wlevel range 0..2^ADDRSIZE.
REQ-027 walmost_full SHALL be registered, computed from the same-cycle difference as wlevel (same latency).
REQ-028 wlevel is pessimistic (read pointer lags); no correction is applied.

Reset
REQ-029 wrst_n=0 SHALL asynchronously force: state EMPTY, s_ready 0, head/tail 0, wlevel 0, walmost_full 0; winc therefore 0.
REQ-030 First cycle after wrst_n deasserts, s_ready SHALL rise to 1 at the next clock edge.
REQ-031 Reset mid-operation SHALL discard buffered words with no winc during or after assertion.

Verification
REQ-032 Reset, then s_valid=1 with data 0x01..0x10 continuously, wfull=0 -> winc high from cycle 2, wdata 0x01..0x10 in order, s_ready stays 1.
REQ-033 Accept 0xA1,0xA2 then hold wfull=1 for 5 cycles -> s_ready=0, winc=0, state TWO; release wfull -> wdata 0xA1 then 0xA2.
REQ-034 Alternate s_valid 1/0 with wfull toggling randomly for 1000 words -> output sequence equals input sequence, no loss or repeats.
REQ-035 wptr=Gray(13), wq2_rptr=Gray(0) -> next cycle wlevel=13, walmost_full=0; wptr=Gray(14) -> wlevel=14, walmost_full=1.
REQ-036 Wrap: wptr=Gray(3), wq2_rptr=Gray(27) -> wlevel=8; wptr=Gray(5), wq2_rptr=Gray(21) -> wlevel=16, walmost_full=1.
REQ-037 Assert wrst_n=0 in state TWO mid-stream -> winc=0, s_ready=0, wlevel=0 immediately; after release no stale word written.

Source files
------------

// File: rtl/wr_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// wr_stream_ctrl_if
//   Bundles the signals of wr_stream_ctrl other than clock and reset:
//   the upstream valid/ready stream, the write strobe and data toward the
//   FIFO, and the pointer, full and level signals exchanged with the
//   write-pointer/full logic.
//
//   Signals
//     s_valid, s_data   upstream word and its valid
//     s_ready           block can accept a word this cycle
//     winc, wdata       write strobe and word toward FIFO memory
//     wfull             registered full flag
//     wptr, wq2_rptr    Gray write pointer / synchronized Gray read pointer
//     wlevel            write-side fill estimate, words
//     walmost_full      wlevel >= almost-full threshold
//
//   Modports
//     slave   the wr_stream_ctrl block itself
//     master  its surroundings (upstream source plus pointer/full logic)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface wr_stream_ctrl_if #(
  parameter int DSIZE    = 8,
  parameter int ADDRSIZE = 4
);
  logic                s_valid;
  logic [DSIZE-1:0]    s_data;
  logic                s_ready;
  logic                winc;
  logic [DSIZE-1:0]    wdata;
  logic                wfull;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE:0]   wlevel;
  logic                walmost_full;

  modport slave (
    input  s_valid, s_data, wfull, wptr, wq2_rptr,
    output s_ready, winc, wdata, wlevel, walmost_full
  );

  modport master (
    output s_valid, s_data, wfull, wptr, wq2_rptr,
    input  s_ready, winc, wdata, wlevel, walmost_full
  );
endinterface

// File: rtl/wr_stream_ctrl.sv
// ---------------------------------------------------------------------------
// wr_stream_ctrl
//   Write-side front end of an asynchronous FIFO.
//   * A 2-entry skid buffer (head, tail) decouples the upstream valid/ready
//     stream from the FIFO write strobe so s_ready can be a plain register
//     while still sustaining one word per cycle.
//   * A fill estimate is derived from the Gray write pointer and the
//     synchronized Gray read pointer. Because the read pointer lags, the
//     estimate is pessimistic (never below the true fill).
//
//   Ports
//     wclk     write-domain clock, rising edge
//     wrst_n   asynchronous active-low reset
//     bus      wr_stream_ctrl_if.slave (see interface file for signals)
//
//   Parameters
//     DSIZE      data word width
//     ADDRSIZE   FIFO address width, depth = 2**ADDRSIZE
//     AF_THRESH  almost-full threshold in words, 1..2**ADDRSIZE
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module wr_stream_ctrl #(
  parameter int DSIZE     = 8,
  parameter int ADDRSIZE  = 4,
  parameter int AF_THRESH = 14
) (
  input  logic           wclk,
  input  logic           wrst_n,
  wr_stream_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [ADDRSIZE:0] AF_LVL = (ADDRSIZE+1)'(AF_THRESH);

  // -------------------------------------------------------------------------
  // Skid buffer
  // -------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [DSIZE-1:0] r_head;
  logic [DSIZE-1:0] r_tail;
  logic [DSIZE-1:0] w_head_nxt;
  logic [DSIZE-1:0] w_tail_nxt;
  logic             r_s_ready;
  logic             w_push;
  logic             w_pop;

  assign w_push = bus.s_valid & r_s_ready;
  assign w_pop  = (r_state != ST_EMPTY) & ~bus.wfull;

  assign bus.s_ready = r_s_ready;
  assign bus.winc    = w_pop;
  assign bus.wdata   = r_head;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state   <= ST_EMPTY;
      r_s_ready <= 1'b0;
      // NOTE: the two data entries are explicitly reset; they are only two
      // flops wide in depth, and a clean zero keeps wdata defined out of reset.
      r_head    <= '0;
      r_tail    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_head    <= w_head_nxt;
      r_tail    <= w_tail_nxt;
      // Ready for the coming cycle is known from where the buffer is heading,
      // which keeps s_ready a register with no combinational path from wfull.
      r_s_ready <= (w_state_nxt != ST_TWO);
    end
  end

  // NOTE: every output of this block gets a hold default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt = ST_ONE;
          w_head_nxt  = bus.s_data;
        end
      end
      ST_ONE: begin
        if (w_push && !w_pop) begin
          w_state_nxt = ST_TWO;
          w_tail_nxt  = bus.s_data;
        end else if (w_pop && !w_push) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_push && w_pop) begin
          // Head is written out this cycle; the new word replaces it.
          w_head_nxt  = bus.s_data;
        end
      end
      ST_TWO: begin
        // s_ready is low here, so only a downstream transfer can occur.
        if (w_pop) begin
          w_state_nxt = ST_ONE;
          w_head_nxt  = r_tail;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Fill estimate
  // -------------------------------------------------------------------------
  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] w_wbin;
  logic [ADDRSIZE:0] w_rbin;
  logic [ADDRSIZE:0] w_diff;
  logic [ADDRSIZE:0] r_wlevel;
  logic              r_walmost_full;

  assign w_wbin = gray2bin(bus.wptr);
  assign w_rbin = gray2bin(bus.wq2_rptr);
  // Pointers carry one extra wrap bit, so a subtraction truncated to
  // ADDRSIZE+1 bits yields the correct occupancy across pointer wrap.
  assign w_diff = w_wbin - w_rbin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wlevel       <= '0;
      r_walmost_full <= 1'b0;
    end else begin
      r_wlevel       <= w_diff;
      r_walmost_full <= (w_diff >= AF_LVL);
    end
  end

  assign bus.wlevel       = r_wlevel;
  assign bus.walmost_full = r_walmost_full;

endmodule

// File: tb/tb_wr_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wr_stream_ctrl
//   Self-checking bench for wr_stream_ctrl. Inputs change on the falling
//   edge and outputs are sampled 1 ns later, away from the rising edge.
//   Accepted words are queued in a scoreboard and compared as they are
//   written out; a small occupancy model predicts s_ready and winc.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wr_stream_ctrl;

  localparam int DSIZE     = 8;
  localparam int ADDRSIZE  = 4;
  localparam int AF_THRESH = 14;

  logic wclk = 1'b0;
  logic wrst_n;

  always #5 wclk = ~wclk;

  wr_stream_ctrl_if #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE)) bus ();

  wr_stream_ctrl #(
    .DSIZE     (DSIZE),
    .ADDRSIZE  (ADDRSIZE),
    .AF_THRESH (AF_THRESH)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int               n_vec = 0;
  int               n_err = 0;
  logic [DSIZE-1:0] sb[$];
  bit               m_ready;
  int               m_cnt;
  logic [ADDRSIZE:0] m_lvl;
  bit               m_af;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [ADDRSIZE:0] to_gray(input logic [ADDRSIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  // One clock of stream traffic: drive, check against the model, advance.
  task automatic cycle(input bit v, input logic [DSIZE-1:0] d, input bit f,
                       output bit acc);
    logic [DSIZE-1:0] exp_w;
    bit               pop;
    bus.s_valid = v;
    bus.s_data  = d;
    bus.wfull   = f;
    #1;
    pop = (m_cnt != 0) && !f;
    check("s_ready", 32'(bus.s_ready), 32'(m_ready));
    check("winc",    32'(bus.winc),    32'(pop));
    if (bus.winc === 1'b1) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_w = sb.pop_front();
        check("wdata", 32'(bus.wdata), 32'(exp_w));
      end
    end
    acc = v && m_ready;
    if (acc) sb.push_back(d);
    m_cnt   = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
    m_ready = (m_cnt != 2);
    @(negedge wclk);
  endtask

  // Apply binary pointer values; level must hold for now, update after one edge.
  task automatic lvl(input logic [ADDRSIZE:0] wp, input logic [ADDRSIZE:0] rp,
                     input int exp_l, input bit exp_af);
    bus.wptr     = to_gray(wp);
    bus.wq2_rptr = to_gray(rp);
    #1;
    check("wlevel_hold", 32'(bus.wlevel), 32'(m_lvl));
    check("walmost_full_hold", 32'(bus.walmost_full), 32'(m_af));
    @(negedge wclk);
    check("wlevel", 32'(bus.wlevel), 32'(exp_l));
    check("walmost_full", 32'(bus.walmost_full), 32'(exp_af));
    m_lvl = (ADDRSIZE+1)'(exp_l);
    m_af  = exp_af;
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt   = 0;
    m_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int d;
    int cnt;
    int k;
    logic [ADDRSIZE:0] rp;

    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.wfull    = 1'b0;
    bus.wptr     = '0;
    bus.wq2_rptr = '0;
    wrst_n       = 1'b0;
    model_reset();
    m_lvl = '0;
    m_af  = 1'b0;

    // Reset state
    @(negedge wclk);
    #1;
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_winc",    32'(bus.winc),    32'd0);
    check("rst_wlevel",  32'(bus.wlevel),  32'd0);
    check("rst_walmost_full", 32'(bus.walmost_full), 32'd0);
    check("rst_wdata",   32'(bus.wdata),   32'd0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Continuous stream 0x01..0x10 with wfull low
    d = 1;
    for (int c = 0; c < 100 && d <= 16; c++) begin
      cycle(1'b1, 8'(d), 1'b0, acc);
      if (acc) d++;
    end
    check("stream_done", 32'(d), 32'd17);
    for (int c = 0; c < 4; c++) cycle(1'b0, 8'h00, 1'b0, acc);

    // Two words absorbed while full, then released in order
    cycle(1'b1, 8'hA1, 1'b1, acc);
    cycle(1'b1, 8'hA2, 1'b1, acc);
    for (int c = 0; c < 5; c++) cycle(1'b1, 8'hEE, 1'b1, acc);
    for (int c = 0; c < 3; c++) cycle(1'b0, 8'h00, 1'b0, acc);
    check("full_drained", 32'(sb.size()), 32'd0);

    // Alternating valid with random backpressure, 1000 words
    cnt = 0;
    for (int c = 0; c < 20000 && cnt < 1000; c++) begin
      cycle(c[0] == 1'b0, 8'($urandom), 1'($urandom_range(0, 1)), acc);
      if (acc) cnt++;
    end
    check("random_count", 32'(cnt), 32'd1000);
    for (int c = 0; c < 6; c++) cycle(1'b0, 8'h00, 1'b0, acc);
    check("random_drained", 32'(sb.size()), 32'd0);

    // Fill-level estimate, including threshold and pointer wrap
    lvl(5'd13, 5'd0,  13, 1'b0);
    lvl(5'd14, 5'd0,  14, 1'b1);
    lvl(5'd3,  5'd27, 8,  1'b0);
    lvl(5'd5,  5'd21, 16, 1'b1);
    lvl(5'd0,  5'd0,  0,  1'b0);
    for (int i = 0; i < 8; i++) begin
      rp = 5'($urandom_range(0, 31));
      k  = $urandom_range(0, 16);
      lvl(rp + 5'(k), rp, k, k >= AF_THRESH);
    end

    // Reset while two words are buffered
    lvl(5'd9, 5'd0, 9, 1'b0);
    cycle(1'b1, 8'hB1, 1'b1, acc);
    cycle(1'b1, 8'hB2, 1'b1, acc);
    bus.s_valid = 1'b1;
    bus.wfull   = 1'b0;
    #2;
    wrst_n = 1'b0;
    #1;
    check("midrst_winc",    32'(bus.winc),    32'd0);
    check("midrst_s_ready", 32'(bus.s_ready), 32'd0);
    check("midrst_wlevel",  32'(bus.wlevel),  32'd0);
    check("midrst_walmost_full", 32'(bus.walmost_full), 32'd0);
    bus.wptr     = '0;
    bus.wq2_rptr = '0;
    @(negedge wclk);
    check("midrst_winc_held", 32'(bus.winc), 32'd0);
    wrst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 5; c++) cycle(1'b0, 8'h00, 1'b0, acc);
    check("postrst_wlevel", 32'(bus.wlevel), 32'd0);
    cycle(1'b1, 8'hC1, 1'b0, acc);
    cycle(1'b1, 8'hC2, 1'b0, acc);
    for (int c = 0; c < 3; c++) cycle(1'b0, 8'h00, 1'b0, acc);
    check("postrst_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
